// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file write side.
//   - N_DEF / W_DEF / M_DEF : default address width, data width, register count
//   - wr_req_t              : write request {adr, data} at default widths
//   - occ_state_e           : request queue occupancy states
//   - onehot()              : address to one-hot strobe decode
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int N_DEF = 2;
    localparam int W_DEF = 16;
    localparam int M_DEF = 1 << N_DEF;

    // onehot() works on a wide fixed-size vector so any N up to ONEHOT_MAX_N
    // can share it; callers widen the address and keep the low M bits.
    localparam int ONEHOT_MAX_N = 8;
    localparam int ONEHOT_MAX_M = 1 << ONEHOT_MAX_N;

    typedef struct packed {
        logic [N_DEF-1:0] adr;
        logic [W_DEF-1:0] data;
    } wr_req_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_e;

    function automatic logic [ONEHOT_MAX_M-1:0] onehot(input logic [ONEHOT_MAX_N-1:0] adr);
        logic [ONEHOT_MAX_M-1:0] v;
        v      = '0;
        v[adr] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wr_req_fifo.sv
// -----------------------------------------------------------------------------
// wr_req_fifo
// In-order circular buffer of DEPTH write requests {adr, data}.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   push_i, adr_i, data_i  enqueue request (ignored when full)
//   pop_i                  dequeue head (ignored when empty)
//   head_adr_o/head_data_o entry at the read pointer
//   full_o, empty_o        occupancy flags
//   queued_mask_o          OR of one-hot(adr) over all valid entries
// -----------------------------------------------------------------------------
module wr_req_fifo
    import regfile_pkg::*;
#(
    parameter  int N     = N_DEF,
    parameter  int W     = W_DEF,
    parameter  int DEPTH = 2,
    localparam int M     = 1 << N,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [N-1:0] adr_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [N-1:0] head_adr_o,
    output logic [W-1:0] head_data_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [M-1:0] queued_mask_o
);

    logic [N-1:0]     adr_q  [DEPTH];
    logic [W-1:0]     data_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    occ_state_e       occ_q, occ_d;

    logic push_ok;
    logic pop_ok;

    logic [PTR_W-1:0]        offs;
    logic [ONEHOT_MAX_M-1:0] oh;

    assign full_o  = (occ_q == OCC_FULL);
    assign empty_o = (occ_q == OCC_EMPTY);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    assign head_adr_o  = adr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];

    // Pointers wrap naturally since DEPTH is a power of two; a simultaneous
    // push and pop leaves the count unchanged while both pointers advance.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Occupancy state tracks the next count, so the flags come straight
    // from a register rather than a compare on the count.
    always_comb begin
        occ_d = OCC_PARTIAL;
        if (count_d == '0) begin
            occ_d = OCC_EMPTY;
        end else if (count_d == CNT_W'(DEPTH)) begin
            occ_d = OCC_FULL;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            occ_q    <= OCC_EMPTY;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset: validity is defined by pointers and count.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            adr_q[wr_ptr_q]  <= adr_i;
            data_q[wr_ptr_q] <= data_i;
        end
    end

    // An entry is valid when its distance from the read pointer is below
    // the occupancy count.
    always_comb begin
        queued_mask_o = '0;
        offs          = '0;
        oh            = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PTR_W'(i) - rd_ptr_q;
            oh   = onehot(ONEHOT_MAX_N'(adr_q[i]));
            if ({1'b0, offs} < count_q) begin
                queued_mask_o = queued_mask_o | oh[M-1:0];
            end
        end
    end

endmodule

// File: rtl/reg_write_decoder.sv
// -----------------------------------------------------------------------------
// reg_write_decoder
// Write-side decoder for the register file. Requests are queued in order and
// drained one per cycle as a registered one-hot strobe plus data.
// Ports:
//   Clk, Reset_n       clock, asynchronous active-low reset
//   W_adr, W_data      write request; W_ena marks it valid
//   W_rdy              queue can accept (transfer on W_ena && W_rdy)
//   Hold               register file busy, stalls the drain
//   Oew, Wdata_out     registered one-hot write strobe and its data
//   Pending            registers targeted by queued or in-flight writes
//   Wr_cnt             writes strobed out, wraps at 16 bits
// Optional feature macro WR_ZERO_PROTECT_EN: register 0 is hard-wired; writes
// to address 0 handshake but are dropped and never strobed or counted.
// -----------------------------------------------------------------------------
module reg_write_decoder
    import regfile_pkg::*;
#(
    parameter  int N     = N_DEF,
    parameter  int W     = W_DEF,
    parameter  int DEPTH = 2,
    localparam int M     = 1 << N
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic [N-1:0] W_adr,
    input  logic [W-1:0] W_data,
    input  logic         W_ena,
    output logic         W_rdy,
    input  logic         Hold,
    output logic [M-1:0] Oew,
    output logic [W-1:0] Wdata_out,
    output logic [M-1:0] Pending,
    output logic [15:0]  Wr_cnt
);

`ifdef WR_ZERO_PROTECT_EN
    localparam logic [M-1:0] KEEP_MASK = {{(M-1){1'b1}}, 1'b0};
`else
    localparam logic [M-1:0] KEEP_MASK = '1;
`endif

    logic         accept;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    logic [N-1:0] head_adr;
    logic [W-1:0] head_data;
    logic [M-1:0] queued_mask;

    logic [ONEHOT_MAX_M-1:0] head_oh;

    logic [M-1:0]  oew_q, oew_d;
    logic [W-1:0]  wdata_q, wdata_d;
    logic [15:0]   wr_cnt_q, wr_cnt_d;

    // W_rdy looks only at the registered occupancy, never at a same-cycle
    // drain, so a full queue makes the requester wait one extra cycle.
    assign W_rdy  = !full;
    assign accept = W_ena && W_rdy;

`ifdef WR_ZERO_PROTECT_EN
    assign push = accept && (W_adr != '0);
`else
    assign push = accept;
`endif

    assign pop = !empty && !Hold;

    wr_req_fifo #(
        .N     (N),
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i         (Clk),
        .rst_ni        (Reset_n),
        .push_i        (push),
        .adr_i         (W_adr),
        .data_i        (W_data),
        .pop_i         (pop),
        .head_adr_o    (head_adr),
        .head_data_o   (head_data),
        .full_o        (full),
        .empty_o       (empty),
        .queued_mask_o (queued_mask)
    );

    // Strobe is a single-cycle pulse per drained entry; data holds its last
    // value while idle so the register file sees no spurious toggling.
    always_comb begin
        head_oh  = onehot(ONEHOT_MAX_N'(head_adr));
        oew_d    = '0;
        wdata_d  = wdata_q;
        wr_cnt_d = wr_cnt_q;
        if (pop) begin
            oew_d    = head_oh[M-1:0];
            wdata_d  = head_data;
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            oew_q    <= '0;
            wdata_q  <= '0;
            wr_cnt_q <= '0;
        end else begin
            oew_q    <= oew_d;
            wdata_q  <= wdata_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign Oew       = oew_q & KEEP_MASK;
    assign Wdata_out = wdata_q;
    assign Wr_cnt    = wr_cnt_q;
    assign Pending   = (queued_mask | oew_q) & KEEP_MASK;

endmodule

// File: tb/tb_reg_write_decoder.sv
// -----------------------------------------------------------------------------
// tb_reg_write_decoder
// Directed self-checking bench for reg_write_decoder (N=2, W=16, DEPTH=2).
// Honours WR_ZERO_PROTECT_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_reg_write_decoder;

    logic        Clk;
    logic        Reset_n;
    logic [1:0]  W_adr;
    logic [15:0] W_data;
    logic        W_ena;
    logic        W_rdy;
    logic        Hold;
    logic [3:0]  Oew;
    logic [15:0] Wdata_out;
    logic [3:0]  Pending;
    logic [15:0] Wr_cnt;

    int checks;
    int errors;

    reg_write_decoder #(
        .N     (2),
        .W     (16),
        .DEPTH (2)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .W_adr     (W_adr),
        .W_data    (W_data),
        .W_ena     (W_ena),
        .W_rdy     (W_rdy),
        .Hold      (Hold),
        .Oew       (Oew),
        .Wdata_out (Wdata_out),
        .Pending   (Pending),
        .Wr_cnt    (Wr_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        W_ena   = 1'b0;
        W_adr   = '0;
        W_data  = '0;
        Hold    = 1'b0;
        #12;
        checks++;
        if (W_rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_w_rdy got %b expected 1", W_rdy); end
        checks++;
        if (Oew !== 4'b0000) begin errors++; $display("[TB] FAIL reset_oew got %b expected 0000", Oew); end
        checks++;
        if (Pending !== 4'b0000) begin errors++; $display("[TB] FAIL reset_pending got %b expected 0000", Pending); end
        checks++;
        if (Wr_cnt !== 16'h0000) begin errors++; $display("[TB] FAIL reset_wr_cnt got %h expected 0000", Wr_cnt); end
        checks++;
        if (Wdata_out !== 16'h0000) begin errors++; $display("[TB] FAIL reset_wdata got %h expected 0000", Wdata_out); end
        @(negedge Clk);
        Reset_n = 1'b1;
        step();
    endtask

    task automatic test_single_write();
        W_adr  = 2'd2;
        W_data = 16'h1234;
        W_ena  = 1'b1;
        step();
        W_ena = 1'b0;
        checks++;
        if (Oew !== 4'b0000) begin errors++; $display("[TB] FAIL single_no_bypass got %b expected 0000", Oew); end
        checks++;
        if (Pending !== 4'b0100) begin errors++; $display("[TB] FAIL single_pending_queued got %b expected 0100", Pending); end
        step();
        checks++;
        if (Oew !== 4'b0100) begin errors++; $display("[TB] FAIL single_oew got %b expected 0100", Oew); end
        checks++;
        if (Wdata_out !== 16'h1234) begin errors++; $display("[TB] FAIL single_wdata got %h expected 1234", Wdata_out); end
        checks++;
        if (Wr_cnt !== 16'd1) begin errors++; $display("[TB] FAIL single_wr_cnt got %0d expected 1", Wr_cnt); end
        step();
        checks++;
        if (Oew !== 4'b0000) begin errors++; $display("[TB] FAIL single_pulse_end got %b expected 0000", Oew); end
        checks++;
        if (Pending !== 4'b0000) begin errors++; $display("[TB] FAIL single_pending_clear got %b expected 0000", Pending); end
        checks++;
        if (Wdata_out !== 16'h1234) begin errors++; $display("[TB] FAIL single_wdata_hold got %h expected 1234", Wdata_out); end
    endtask

    task automatic test_fill_stall();
        Hold   = 1'b1;
        W_adr  = 2'd1;
        W_data = 16'h0011;
        W_ena  = 1'b1;
        step();
        checks++;
        if (W_rdy !== 1'b1) begin errors++; $display("[TB] FAIL fill_rdy_partial got %b expected 1", W_rdy); end
        W_adr  = 2'd3;
        W_data = 16'h0033;
        step();
        checks++;
        if (W_rdy !== 1'b0) begin errors++; $display("[TB] FAIL fill_rdy_full got %b expected 0", W_rdy); end
        checks++;
        if (Pending !== 4'b1010) begin errors++; $display("[TB] FAIL fill_pending got %b expected 1010", Pending); end
        // Third request is presented but must wait while full.
        W_adr  = 2'd2;
        W_data = 16'h0022;
        step();
        checks++;
        if (W_rdy !== 1'b0 || Oew !== 4'b0000 || Pending !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL fill_third_waits got rdy=%b oew=%b pend=%b expected rdy=0 oew=0000 pend=1010", W_rdy, Oew, Pending);
        end
        Hold = 1'b0;
        step();
        checks++;
        if (Oew !== 4'b0010 || Wdata_out !== 16'h0011) begin
            errors++;
            $display("[TB] FAIL drain_first got oew=%b data=%h expected oew=0010 data=0011", Oew, Wdata_out);
        end
        checks++;
        if (W_rdy !== 1'b1) begin errors++; $display("[TB] FAIL drain_rdy_back got %b expected 1", W_rdy); end
        checks++;
        if (Pending !== 4'b1010) begin errors++; $display("[TB] FAIL drain_pending_mid got %b expected 1010", Pending); end
        step();
        W_ena = 1'b0;
        checks++;
        if (Oew !== 4'b1000 || Wdata_out !== 16'h0033) begin
            errors++;
            $display("[TB] FAIL drain_second got oew=%b data=%h expected oew=1000 data=0033", Oew, Wdata_out);
        end
        checks++;
        if (Pending !== 4'b1100) begin errors++; $display("[TB] FAIL drain_pending_third got %b expected 1100", Pending); end
        step();
        checks++;
        if (Oew !== 4'b0100 || Wdata_out !== 16'h0022) begin
            errors++;
            $display("[TB] FAIL drain_third got oew=%b data=%h expected oew=0100 data=0022", Oew, Wdata_out);
        end
        step();
        checks++;
        if (Oew !== 4'b0000 || Pending !== 4'b0000 || Wr_cnt !== 16'd4) begin
            errors++;
            $display("[TB] FAIL drain_idle got oew=%b pend=%b cnt=%0d expected oew=0000 pend=0000 cnt=4", Oew, Pending, Wr_cnt);
        end
    endtask

    task automatic test_same_address();
        W_adr  = 2'd1;
        W_data = 16'h00AA;
        W_ena  = 1'b1;
        step();
        W_data = 16'h00BB;
        step();
        W_ena = 1'b0;
        checks++;
        if (Oew !== 4'b0010 || Wdata_out !== 16'h00AA) begin
            errors++;
            $display("[TB] FAIL same_adr_first got oew=%b data=%h expected oew=0010 data=00aa", Oew, Wdata_out);
        end
        step();
        checks++;
        if (Oew !== 4'b0010 || Wdata_out !== 16'h00BB) begin
            errors++;
            $display("[TB] FAIL same_adr_second got oew=%b data=%h expected oew=0010 data=00bb", Oew, Wdata_out);
        end
        step();
        checks++;
        if (Oew !== 4'b0000 || Wr_cnt !== 16'd6) begin
            errors++;
            $display("[TB] FAIL same_adr_end got oew=%b cnt=%0d expected oew=0000 cnt=6", Oew, Wr_cnt);
        end
    endtask

    task automatic test_zero_address();
        checks++;
        if (W_rdy !== 1'b1) begin errors++; $display("[TB] FAIL zero_rdy got %b expected 1", W_rdy); end
        W_adr  = 2'd0;
        W_data = 16'hFFFF;
        W_ena  = 1'b1;
        step();
        W_ena = 1'b0;
        step();
`ifdef WR_ZERO_PROTECT_EN
        checks++;
        if (Oew !== 4'b0000 || Pending[0] !== 1'b0 || Wr_cnt !== 16'd6) begin
            errors++;
            $display("[TB] FAIL zero_protect got oew=%b pend0=%b cnt=%0d expected oew=0000 pend0=0 cnt=6", Oew, Pending[0], Wr_cnt);
        end
`else
        checks++;
        if (Oew !== 4'b0001 || Wdata_out !== 16'hFFFF || Wr_cnt !== 16'd7) begin
            errors++;
            $display("[TB] FAIL zero_plain got oew=%b data=%h cnt=%0d expected oew=0001 data=ffff cnt=7", Oew, Wdata_out, Wr_cnt);
        end
`endif
        step();
        checks++;
        if (Oew !== 4'b0000 || Pending !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL zero_idle got oew=%b pend=%b expected 0000 0000", Oew, Pending);
        end
    endtask

    task automatic test_reset_mid();
        Hold   = 1'b1;
        W_ena  = 1'b1;
        W_adr  = 2'd2;
        W_data = 16'h0B0B;
        step();
        W_adr  = 2'd1;
        W_data = 16'h0C0C;
        step();
        W_ena = 1'b0;
        checks++;
        if (Pending !== 4'b0110 || W_rdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_preload got pend=%b rdy=%b expected pend=0110 rdy=0", Pending, W_rdy);
        end
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if (Oew !== 4'b0000 || Pending !== 4'b0000 || W_rdy !== 1'b1 || Wr_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset got oew=%b pend=%b rdy=%b cnt=%0d expected 0000 0000 1 0", Oew, Pending, W_rdy, Wr_cnt);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        Hold    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (Oew !== 4'b0000 || Wr_cnt !== 16'd0) begin
                errors++;
                $display("[TB] FAIL mid_no_strobe cycle %0d got oew=%b cnt=%0d expected 0000 0", i, Oew, Wr_cnt);
            end
        end
    endtask

    task automatic test_pointer_wrap();
        logic [1:0]  adrs  [5];
        logic [15:0] datas [5];
        logic [3:0]  exp_oew;
        adrs[0] = 2'd3; adrs[1] = 2'd1; adrs[2] = 2'd2; adrs[3] = 2'd3; adrs[4] = 2'd1;
        for (int i = 0; i < 5; i++) begin
            datas[i] = 16'hA0 + 16'(i);
        end
        W_ena = 1'b1;
        for (int i = 0; i < 5; i++) begin
            W_adr  = adrs[i];
            W_data = datas[i];
            checks++;
            if (W_rdy !== 1'b1) begin errors++; $display("[TB] FAIL wrap_rdy %0d got %b expected 1", i, W_rdy); end
            step();
            if (i > 0) begin
                exp_oew = 4'b0001 << adrs[i-1];
                checks++;
                if (Oew !== exp_oew || Wdata_out !== datas[i-1]) begin
                    errors++;
                    $display("[TB] FAIL wrap_order %0d got oew=%b data=%h expected oew=%b data=%h", i - 1, Oew, Wdata_out, exp_oew, datas[i-1]);
                end
            end
        end
        W_ena = 1'b0;
        step();
        exp_oew = 4'b0001 << adrs[4];
        checks++;
        if (Oew !== exp_oew || Wdata_out !== datas[4] || Wr_cnt !== 16'd5) begin
            errors++;
            $display("[TB] FAIL wrap_last got oew=%b data=%h cnt=%0d expected oew=%b data=%h cnt=5", Oew, Wdata_out, Wr_cnt, exp_oew, datas[4]);
        end
    endtask

    task automatic test_counter_wrap();
        int accepted;
        int guard;
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        Reset_n = 1'b1;
        Hold     = 1'b0;
        accepted = 0;
        guard    = 0;
        W_adr    = 2'd1;
        W_ena    = 1'b1;
        while (accepted < 65535 && guard < 70000) begin
            W_data = 16'(accepted);
            if (W_rdy) accepted++;
            step();
            guard++;
        end
        W_ena = 1'b0;
        checks++;
        if (accepted != 65535) begin
            errors++;
            $display("[TB] FAIL cnt_stream_timeout got %0d accepted expected 65535", accepted);
        end
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (Wr_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL cnt_full got %h expected ffff", Wr_cnt); end
        W_data = 16'h5A5A;
        W_ena  = 1'b1;
        step();
        W_ena = 1'b0;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (Wr_cnt !== 16'h0000) begin errors++; $display("[TB] FAIL cnt_wrap got %h expected 0000", Wr_cnt); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_write();
        test_fill_stall();
        test_same_address();
        test_zero_address();
        test_reset_mid();
        test_pointer_wrap();
        test_counter_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_write_decoder.md
Name: reg_write_decoder

Overview:
Write-side companion to the register file's dual read decoder. Accepts write requests (address + data) from the execute/load paths. Buffers them in a small in-order queue and drains one per cycle as a registered one-hot write strobe plus data to the register file. Also exports a pending-write bitmap so the read side can detect read-after-write hazards.

Parameters:
N, 2, address width; M = 2**N registers (localparam)
W, 16, data word width
DEPTH, 2, request queue depth in entries (power of two, >= 2)

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset_n  input  1  asynchronous, active-low reset
W_adr  input  N  write address of request
W_data  input  W  write data of request
W_ena  input  1  request valid
W_rdy  output  1  queue can accept; transfer occurs on W_ena && W_rdy at a rising edge
Hold  input  1  register file cannot take a write this cycle; stalls drain
Oew  output  M  registered one-hot write strobe to register-file loads; all zero when idle
Wdata_out  output  W  registered data accompanying Oew
Pending  output  M  combinational OR of one-hot(address) over all queued entries and the in-flight Oew
Wr_cnt  output  16  count of writes strobed out, wraps 0xFFFF -> 0

Behaviour:
- Reset (Reset_n low, asynchronous): queue emptied (read and write pointers and count = 0), Oew = 0, Wdata_out = 0, Wr_cnt = 0. W_rdy = 1 and Pending = 0 immediately. Queued and in-flight writes are discarded, never strobed.
- Queue: circular buffer of DEPTH entries {adr, data}. Pointers wrap modulo DEPTH. Occupancy counter is width clog2(DEPTH)+1.
- W_rdy = (count != DEPTH). It does not depend on a same-cycle dequeue, so when full, enqueue waits even if a drain occurs.
- Enqueue: on an edge with W_ena && W_rdy, write the entry at the write pointer and advance the pointer. W_adr/W_data are ignored when W_ena = 0.
- Drain: on an edge with count != 0 && !Hold:
  - Oew <= 1 << head.adr; Wdata_out <= head.data.
  - Advance the read pointer.
  - Wr_cnt <= Wr_cnt + 1.
- Otherwise Oew <= 0, and Wdata_out holds its last value.
- Oew is a one-cycle pulse per write. Back-to-back drains give consecutive one-hot pulses.
- Simultaneous enqueue and dequeue with 0 < count < DEPTH: count is unchanged, and both pointers advance.
- Latency with the queue empty and Hold = 0: request accepted at edge t, Oew asserted in the cycle after edge t+1. No bypass path.
- Hold asserted: no dequeue. Oew drops to 0 on the next edge. The queue retains order, and W_rdy stays 1 until the queue fills.
- Ordering: strictly FIFO. Two writes to the same address reach the register file in issue order.
- Pending: a bit is set while any queued entry or the current Oew targets that register. It clears the cycle after the last strobe to that address.
- State summary (per occupancy): EMPTY (count = 0), PARTIAL, FULL (count = DEPTH).
  - Transitions are driven by enqueue/dequeue as above.
  - FULL -> PARTIAL only via drain.

Optional Feature:
Macro WR_ZERO_PROTECT_EN.
- Defined: register 0 is hard-wired.
  - Requests with W_adr = 0 complete the handshake (consume W_rdy) but are not enqueued.
  - Oew[0] and Pending[0] are constant 0, and Wr_cnt does not increment for them.
- Undefined: address 0 is treated like any other register.

Decomposition:
- Shared package regfile_pkg: defaults for N and W, localparam M, function onehot(adr) returning 1 << adr, and the write-request struct/typedef {adr, data}.
- One sub-module is natural: wr_req_fifo (parametric DEPTH circular buffer with full/empty/count). reg_write_decoder wraps it with the decode, strobe register, Pending, and Wr_cnt.

Test Plan:
- Reset mid-operation: queue two writes, Hold = 1, pull Reset_n low. Required: Oew = 0, Pending = 0, W_rdy = 1 immediately; no strobe after release.
- Single write: W_adr = 2, W_data = 0x1234, Hold = 0. Required: Oew = 4'b0100 and Wdata_out = 0x1234 for exactly one cycle, two edges after acceptance; Wr_cnt = 1.
- Fill and stall: Hold = 1, issue writes to adr 1 and adr 3 (DEPTH = 2). Required: W_rdy = 0 after the second; a third request waits; Pending = 4'b1010. Release Hold: Oew = 0010 then 1000 on consecutive cycles; W_rdy returns to 1.
- Same-address ordering: back-to-back writes adr 1 with 0x00AA then 0x00BB. Required: two consecutive Oew = 0010 pulses with data 0x00AA then 0x00BB.
- Wrap: preload Wr_cnt to 0xFFFF via 65535 writes (or force in the bench), then one more write. Required: Wr_cnt = 0x0000. Pointer wrap is checked by 5 writes through a DEPTH = 2 queue with order preserved.
- WR_ZERO_PROTECT_EN defined: write adr 0 with 0xFFFF. Required: handshake completes, Oew stays 0, Pending[0] = 0, Wr_cnt unchanged. Without the macro: Oew = 0001.
